// File: rtl/scoreboard.sv
// Register status table. Each register has a pending flag for variable-latency writes and a
// shift row for fixed-latency writebacks. The hazard detector reads these through combinational lookups.
module scoreboard #(
   parameter int NREGS = 32,
   parameter int ROW_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       iss_a_reg,
   input  logic [4:0]       iss_b_reg,
   input  logic [4:0]       id_a_reg,
   input  logic [4:0]       id_b_reg,
   input  logic [4:0]       id_waw_reg,
   output logic             iss_pending_a,
   output logic             iss_pending_b,
   output logic             id_pending_a,
   output logic             id_pending_b,
   output logic             id_waw_pending,
   output logic [ROW_W-1:0] iss_row_a,
   output logic [ROW_W-1:0] iss_row_b,
   output logic [ROW_W-1:0] id_row_a,
   output logic [ROW_W-1:0] id_row_b,
   output logic [ROW_W-1:0] id_waw_row,
   input  logic             iss_write,
   input  logic [4:0]       iss_dest,
   input  logic             iss_fixed,
   input  logic [2:0]       iss_lat,
   input  logic [2:0]       haz_lat,
   output logic [NREGS-1:0] sb_haz_column,
   input  logic             vl_done,
   input  logic [4:0]       vl_dest,
   output logic             sb_err
);

   localparam int MAX_LAT = ROW_W - 1;

   logic [NREGS-1:0]            pend_reg, pend_next;
   logic [NREGS-1:0][ROW_W-1:0] row_reg, row_next;
   logic                        err_reg, err_next;

   logic             lat_legal;
   logic [ROW_W-1:0] fix_onehot;
   logic             fix_bad;
   logic             vl_bad;
   logic             haz_ok;
   logic [2:0]       haz_idx;

   assign lat_legal = (iss_lat != 3'd0) && (32'(iss_lat) <= MAX_LAT);

   always_comb begin
      fix_onehot = '0;
      for (int k = 1; k < ROW_W; k++) begin
         if (iss_lat == 3'(k)) fix_onehot[k] = 1'b1;
      end
   end

   // Register 0 writes are silently ignored, so they never flag an error.
   assign fix_bad  = iss_write & iss_fixed & (iss_dest != 5'd0) & ~lat_legal;
   assign vl_bad   = vl_done & (vl_dest != 5'd0) & ~pend_reg[vl_dest];
   assign err_next = err_reg | fix_bad | vl_bad;

   // The column reports the slot an instruction in Issue would claim after the next shift.
   assign haz_ok  = 32'(haz_lat) < MAX_LAT;
   assign haz_idx = haz_ok ? haz_lat + 3'd1 : 3'd0;

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign pend_next[gi] = 1'b0;
         assign row_next[gi]  = '0;
      end else begin : g_track
         logic fix_hit;
         logic vl_hit;
         logic var_hit;

         assign fix_hit = iss_write & iss_fixed & lat_legal & (iss_dest == 5'(gi));
         assign var_hit = iss_write & ~iss_fixed & (iss_dest == 5'(gi));
         assign vl_hit  = vl_done & (vl_dest == 5'(gi)) & pend_reg[gi];

         assign row_next[gi] = (row_reg[gi] >> 1)
                             | (fix_hit ? fix_onehot : '0)
                             | {{(ROW_W-1){1'b0}}, vl_hit};
         // A new variable-latency issue wins over a completion on the same register.
         assign pend_next[gi] = var_hit ? 1'b1 : (vl_hit ? 1'b0 : pend_reg[gi]);
      end
      assign sb_haz_column[gi] = haz_ok & row_reg[gi][haz_idx];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pend_reg <= '0;
         row_reg  <= '0;
         err_reg  <= 1'b0;
      end else begin
         pend_reg <= pend_next;
         row_reg  <= row_next;
         err_reg  <= err_next;
      end
   end

   assign iss_pending_a  = pend_reg[iss_a_reg];
   assign iss_pending_b  = pend_reg[iss_b_reg];
   assign id_pending_a   = pend_reg[id_a_reg];
   assign id_pending_b   = pend_reg[id_b_reg];
   assign id_waw_pending = pend_reg[id_waw_reg];
   assign iss_row_a      = row_reg[iss_a_reg];
   assign iss_row_b      = row_reg[iss_b_reg];
   assign id_row_a       = row_reg[id_a_reg];
   assign id_row_b       = row_reg[id_b_reg];
   assign id_waw_row     = row_reg[id_waw_reg];
   assign sb_err         = err_reg;

endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: directed scenarios plus random traffic, checked against a model
// that tracks each in-flight writeback as a (register, cycles-remaining) entry.
module tb_scoreboard;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  iss_a_reg, iss_b_reg, id_a_reg, id_b_reg, id_waw_reg;
   logic        iss_pending_a, iss_pending_b, id_pending_a, id_pending_b, id_waw_pending;
   logic [4:0]  iss_row_a, iss_row_b, id_row_a, id_row_b, id_waw_row;
   logic        iss_write;
   logic [4:0]  iss_dest;
   logic        iss_fixed;
   logic [2:0]  iss_lat;
   logic [2:0]  haz_lat;
   logic [31:0] sb_haz_column;
   logic        vl_done;
   logic [4:0]  vl_dest;
   logic        sb_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int r;
      int cnt;
   } ent_t;

   ent_t        q[$];
   logic [31:0] pend_m;
   logic        err_m;

   scoreboard dut (
      .clock(clock), .reset(reset),
      .iss_a_reg(iss_a_reg), .iss_b_reg(iss_b_reg),
      .id_a_reg(id_a_reg), .id_b_reg(id_b_reg), .id_waw_reg(id_waw_reg),
      .iss_pending_a(iss_pending_a), .iss_pending_b(iss_pending_b),
      .id_pending_a(id_pending_a), .id_pending_b(id_pending_b),
      .id_waw_pending(id_waw_pending),
      .iss_row_a(iss_row_a), .iss_row_b(iss_row_b),
      .id_row_a(id_row_a), .id_row_b(id_row_b), .id_waw_row(id_waw_row),
      .iss_write(iss_write), .iss_dest(iss_dest), .iss_fixed(iss_fixed),
      .iss_lat(iss_lat), .haz_lat(haz_lat), .sb_haz_column(sb_haz_column),
      .vl_done(vl_done), .vl_dest(vl_dest), .sb_err(sb_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] mrow(input int r);
      logic [4:0] v;
      v = '0;
      foreach (q[i]) if (q[i].r == r) v[q[i].cnt] = 1'b1;
      return v;
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      ent_t nq[$];
      bit   vl_ok;
      if (!reset) begin
         q.delete();
         pend_m = '0;
         err_m  = 1'b0;
      end else begin
         foreach (q[i]) if (q[i].cnt > 0) nq.push_back('{q[i].r, q[i].cnt - 1});
         vl_ok = vl_done && vl_dest != 0 && pend_m[vl_dest];
         if (vl_done && vl_dest != 0 && !pend_m[vl_dest]) err_m = 1'b1;
         if (vl_ok) nq.push_back('{int'(vl_dest), 0});
         if (iss_write && iss_dest != 0 && iss_fixed) begin
            if (iss_lat >= 1 && iss_lat <= 4) nq.push_back('{int'(iss_dest), int'(iss_lat)});
            else err_m = 1'b1;
         end
         if (vl_ok) pend_m[vl_dest] = 1'b0;
         if (iss_write && iss_dest != 0 && !iss_fixed) pend_m[iss_dest] = 1'b1;
         q = nq;
      end
   endtask

   task automatic check_all();
      logic [31:0] col;
      logic [4:0]  rv;
      col = '0;
      for (int r = 0; r < 32; r++) begin
         rv = mrow(r);
         if (haz_lat < 4) col[r] = rv[haz_lat + 1];
      end
      chk("iss_pend_a", 32'(iss_pending_a), 32'(pend_m[iss_a_reg]));
      chk("iss_pend_b", 32'(iss_pending_b), 32'(pend_m[iss_b_reg]));
      chk("id_pend_a", 32'(id_pending_a), 32'(pend_m[id_a_reg]));
      chk("id_pend_b", 32'(id_pending_b), 32'(pend_m[id_b_reg]));
      chk("waw_pend", 32'(id_waw_pending), 32'(pend_m[id_waw_reg]));
      chk("iss_row_a", 32'(iss_row_a), 32'(mrow(int'(iss_a_reg))));
      chk("iss_row_b", 32'(iss_row_b), 32'(mrow(int'(iss_b_reg))));
      chk("id_row_a", 32'(id_row_a), 32'(mrow(int'(id_a_reg))));
      chk("id_row_b", 32'(id_row_b), 32'(mrow(int'(id_b_reg))));
      chk("waw_row", 32'(id_waw_row), 32'(mrow(int'(id_waw_reg))));
      chk("haz_column", sb_haz_column, col);
      chk("sb_err", 32'(sb_err), 32'(err_m));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      iss_write = 1'b0; iss_fixed = 1'b0; iss_dest = 5'd0; iss_lat = 3'd0;
      vl_done = 1'b0; vl_dest = 5'd0; haz_lat = 3'd0;
   endtask

   task automatic random_cycle(input bit allow_bad);
      iss_a_reg  = 5'($urandom_range(0, 7));
      iss_b_reg  = 5'($urandom_range(0, 7));
      id_a_reg   = 5'($urandom_range(0, 7));
      id_b_reg   = 5'($urandom_range(0, 31));
      id_waw_reg = 5'($urandom_range(0, 7));
      haz_lat    = 3'($urandom_range(0, 7));
      iss_write  = 1'($urandom_range(0, 1));
      iss_fixed  = 1'($urandom_range(0, 1));
      iss_dest   = 5'($urandom_range(0, 7));
      iss_lat    = 3'($urandom_range(1, 4));
      if (allow_bad && $urandom_range(0, 60) == 0) iss_lat = 3'($urandom_range(5, 7));
      vl_done    = ($urandom_range(0, 2) == 0);
      vl_dest    = 5'($urandom_range(0, 7));
      // Keep completions mostly legal so the error flag stays informative.
      if (!allow_bad && vl_dest != 0 && !pend_m[vl_dest]) vl_done = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      iss_a_reg = 5'd5; iss_b_reg = 5'd9; id_a_reg = 5'd3; id_b_reg = 5'd0; id_waw_reg = 5'd1;
      pend_m = '0; err_m = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Fixed issue r5, latency 3.
      iss_write = 1'b1; iss_fixed = 1'b1; iss_dest = 5'd5; iss_lat = 3'd3;
      tick();
      idle_inputs();
      chk("r5_t1", 32'(iss_row_a), 32'h08);
      tick();
      chk("r5_t2", 32'(iss_row_a), 32'h04);
      haz_lat = 3'd1; #1;
      chk("col_hl1", sb_haz_column, 32'h20);
      haz_lat = 3'd2; #1;
      chk("col_hl2", sb_haz_column, 32'h0);
      haz_lat = 3'd0;
      tick();
      chk("r5_t3", 32'(iss_row_a), 32'h02);
      tick();
      chk("r5_t4", 32'(iss_row_a), 32'h01);
      tick();
      chk("r5_t5", 32'(iss_row_a), 32'h00);
      chk("r5_pend", 32'(iss_pending_a), 32'h0);

      // Variable issue r9, completion four cycles later.
      iss_write = 1'b1; iss_fixed = 1'b0; iss_dest = 5'd9;
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         chk("r9_pend_wait", 32'(iss_pending_b), 32'h1);
         tick();
      end
      chk("r9_pend_last", 32'(iss_pending_b), 32'h1);
      vl_done = 1'b1; vl_dest = 5'd9;
      tick();
      idle_inputs();
      chk("r9_done_row", 32'(iss_row_b), 32'h01);
      chk("r9_done_pend", 32'(iss_pending_b), 32'h0);
      tick();
      chk("r9_clear", 32'(iss_row_b), 32'h00);

      // Completion and a new variable issue to r9 on the same edge.
      iss_write = 1'b1; iss_fixed = 1'b0; iss_dest = 5'd9;
      tick();
      vl_done = 1'b1; vl_dest = 5'd9;
      tick();
      idle_inputs();
      chk("r9_same_pend", 32'(iss_pending_b), 32'h1);
      chk("r9_same_row", 32'(iss_row_b), 32'h01);
      vl_done = 1'b1; vl_dest = 5'd9;
      tick();
      idle_inputs();

      // Illegal latency to r3 is dropped and latches the error.
      iss_write = 1'b1; iss_fixed = 1'b1; iss_dest = 5'd3; iss_lat = 3'd0;
      tick();
      idle_inputs();
      chk("r3_row", 32'(id_row_a), 32'h0);
      chk("err_set", 32'(sb_err), 32'h1);
      tick();
      tick();
      chk("err_held", 32'(sb_err), 32'h1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("err_reset", 32'(sb_err), 32'h0);

      // Writes to r0 are ignored without error.
      iss_a_reg = 5'd0;
      iss_write = 1'b1; iss_fixed = 1'b1; iss_dest = 5'd0; iss_lat = 3'd2;
      tick();
      idle_inputs();
      chk("r0_row", 32'(iss_row_a), 32'h0);
      chk("r0_err", 32'(sb_err), 32'h0);
      tick();
      chk("r0_row2", 32'(iss_row_a), 32'h0);

      // Random traffic with legal protocol, then with occasional violations.
      for (int i = 0; i < 300; i++) begin
         random_cycle(1'b0);
         tick();
      end
      for (int i = 0; i < 200; i++) begin
         random_cycle(1'b1);
         tick();
      end

      // Mid-operation reset with busy state discards everything.
      for (int i = 0; i < 20; i++) begin
         random_cycle(1'b0);
         tick();
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      idle_inputs();
      iss_a_reg = 5'd1; iss_b_reg = 5'd2; id_a_reg = 5'd3; id_b_reg = 5'd4; id_waw_reg = 5'd5;
      #1;
      chk("rst_row_a", 32'(iss_row_a), 32'h0);
      chk("rst_pend_a", 32'(iss_pending_a), 32'h0);
      chk("rst_col", sb_haz_column, 32'h0);
      chk("rst_err", 32'(sb_err), 32'h0);
      for (int i = 0; i < 100; i++) begin
         random_cycle(1'b0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
